// File: rtl/tone_pkg.sv
// Shared types for the tone period meter: period word, FSM state encoding and tick length.
package tone_pkg;

  typedef logic [31:0] period_t;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    MEASURE
  } meter_state_t;

  localparam int TICK_NS = 10;

endpackage

// File: rtl/audio_edge_sync.sv
// Brings the raw tone input into the clock100 domain and emits registered
// one-cycle rise/fall pulses taken from the last two synchronized samples.
module audio_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock100,
  input  logic reset_n,
  input  logic audIn,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   prev_p1;

  always_ff @(posedge clock100 or negedge reset_n) begin
    if (!reset_n) begin
      sync_p0 <= '0;
      prev_p1 <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], audIn};
      // edge stage: compare newest synchronized sample with the one before it
      prev_p1 <= sync_p0[SYNC_STAGES-1];
      rise    <= sync_p0[SYNC_STAGES-1] & ~prev_p1;
      fall    <= ~sync_p0[SYNC_STAGES-1] & prev_p1;
    end
  end

endmodule

// File: rtl/tone_period_meter.sv
// Measures period and high time of a square-wave tone in clock100 ticks and
// hands results off on valid/ready. Define TONE_METER_AVG_EN to report 4-sample averages.
import tone_pkg::*;

module tone_period_meter #(
  parameter period_t MAX_PERIOD  = 32'd10_000_000,
  parameter int      SYNC_STAGES = 2
) (
  input  logic        clock100,
  input  logic        reset_n,
  input  logic        audIn,
  input  logic        enable,
  output logic [31:0] period_out,
  output logic [31:0] high_out,
  output logic        period_valid,
  input  logic        period_ready,
  output logic        overrun,
  output logic        no_tone
);

  function automatic period_t sat_inc(input period_t v);
    return (v >= MAX_PERIOD) ? MAX_PERIOD : v + 32'd1;
  endfunction

  logic         rise, fall;
  meter_state_t state_q, state_d;
  period_t      cnt_q, hi_cap_q, raw_high;
  logic         fall_seen_q;
  logic         cnt_start, raw_res, timeout, hi_load;
  logic         new_res;
  period_t      new_period, new_high;

  audio_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clock100 (clock100),
    .reset_n  (reset_n),
    .audIn    (audIn),
    .rise     (rise),
    .fall     (fall)
  );

  always_ff @(posedge clock100 or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = ARMED;
        ARMED:   if (rise) state_d = MEASURE;
        MEASURE: if (!rise && cnt_q == MAX_PERIOD) state_d = ARMED;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_start = 1'b0;
    raw_res   = 1'b0;
    timeout   = 1'b0;
    hi_load   = 1'b0;
    if (enable) begin
      case (state_q)
        ARMED:   cnt_start = rise;
        MEASURE: begin
          raw_res = rise;
          timeout = !rise && (cnt_q == MAX_PERIOD);
          hi_load = fall && !fall_seen_q && !rise;
        end
        default: ;
      endcase
    end
  end

  // measure stage: period counter and first-fall capture
  always_ff @(posedge clock100 or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q       <= '0;
      hi_cap_q    <= '0;
      fall_seen_q <= 1'b0;
    end else if (!enable) begin
      cnt_q       <= '0;
      fall_seen_q <= 1'b0;
    end else if (cnt_start || raw_res) begin
      cnt_q       <= 32'd1;
      fall_seen_q <= 1'b0;
    end else if (timeout) begin
      cnt_q       <= '0;
    end else if (state_q == MEASURE) begin
      cnt_q <= sat_inc(cnt_q);
      if (hi_load) begin
        hi_cap_q    <= cnt_q;
        fall_seen_q <= 1'b1;
      end
    end
  end

  // A period with no falling edge seen is reported as fully high
  assign raw_high = fall_seen_q ? hi_cap_q : cnt_q;

`ifdef TONE_METER_AVG_EN
  function automatic period_t avg4(input logic [33:0] s);
    return s[33:2];
  endfunction

  logic [33:0] acc_p_q, acc_h_q, sum_p, sum_h;
  logic [1:0]  idx_q;

  assign sum_p = acc_p_q + {2'b00, cnt_q};
  assign sum_h = acc_h_q + {2'b00, raw_high};

  always_ff @(posedge clock100 or negedge reset_n) begin
    if (!reset_n) begin
      acc_p_q <= '0;
      acc_h_q <= '0;
      idx_q   <= '0;
    end else if (!enable || timeout || (raw_res && idx_q == 2'd3)) begin
      acc_p_q <= '0;
      acc_h_q <= '0;
      idx_q   <= '0;
    end else if (raw_res) begin
      acc_p_q <= sum_p;
      acc_h_q <= sum_h;
      idx_q   <= idx_q + 2'd1;
    end
  end

  assign new_res    = raw_res && (idx_q == 2'd3);
  assign new_period = avg4(sum_p);
  assign new_high   = avg4(sum_h);
`else
  assign new_res    = raw_res;
  assign new_period = cnt_q;
  assign new_high   = raw_high;
`endif

  // output stage: holding register with valid/ready handoff
  always_ff @(posedge clock100 or negedge reset_n) begin
    if (!reset_n) begin
      period_out   <= '0;
      high_out     <= '0;
      period_valid <= 1'b0;
      overrun      <= 1'b0;
      no_tone      <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (new_res) begin
        period_out   <= new_period;
        high_out     <= new_high;
        period_valid <= 1'b1;
        overrun      <= period_valid && !period_ready;
      end else if (period_valid && period_ready) begin
        period_valid <= 1'b0;
      end
      if (timeout)      no_tone <= 1'b1;
      else if (new_res) no_tone <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tone_period_meter.sv
// Directed bench for tone_period_meter with MAX_PERIOD shortened to 1000 ticks.
module tb_tone_period_meter;

  logic        clock100 = 1'b0;
  logic        reset_n, audIn, enable, period_ready;
  logic [31:0] period_out, high_out;
  logic        period_valid, overrun, no_tone;

  int          checks = 0;
  int          errors = 0;
  int          n_acc  = 0;
  int          n_ovr  = 0;
  int          base_acc, base_ovr;
  logic [31:0] last_p = '0;
  logic [31:0] last_h = '0;

  always #5 clock100 = ~clock100;

  tone_period_meter #(.MAX_PERIOD(32'd1000), .SYNC_STAGES(2)) dut (
    .clock100     (clock100),
    .reset_n      (reset_n),
    .audIn        (audIn),
    .enable       (enable),
    .period_out   (period_out),
    .high_out     (high_out),
    .period_valid (period_valid),
    .period_ready (period_ready),
    .overrun      (overrun),
    .no_tone      (no_tone)
  );

  always @(negedge clock100) begin
    if (period_valid && period_ready) begin
      n_acc  = n_acc + 1;
      last_p = period_out;
      last_h = high_out;
    end
    if (overrun) n_ovr = n_ovr + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock100);
      #1;
    end
  endtask

  task automatic tone(input int per, input int hi, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      audIn = 1'b1;
      step(hi);
      audIn = 1'b0;
      step(per - hi);
    end
  endtask

  task automatic rearm();
    enable = 1'b0;
    step(2);
    enable = 1'b1;
    step(2);
  endtask

  initial begin
    reset_n      = 1'b0;
    enable       = 1'b0;
    audIn        = 1'b0;
    period_ready = 1'b1;
    step(3);
    chk("rst_valid",   period_valid, 0);
    chk("rst_period",  period_out,   0);
    chk("rst_high",    high_out,     0);
    chk("rst_overrun", overrun,      0);
    chk("rst_no_tone", no_tone,      0);
    reset_n = 1'b1;
    step(2);
    enable = 1'b1;
    step(2);

`ifndef TONE_METER_AVG_EN
    // steady tone, consumer always ready
    base_acc = n_acc; base_ovr = n_ovr;
    tone(600, 300, 4);
    chk("t1_count",   n_acc - base_acc, 3);
    chk("t1_period",  last_p, 600);
    chk("t1_high",    last_h, 300);
    chk("t1_no_tone", no_tone, 0);
    chk("t1_overrun", n_ovr - base_ovr, 0);

    // timeout 1000 ticks after the last rise pulse reaches the FSM
    step(403);
    chk("t3_before", no_tone, 0);
    step(1);
    chk("t3_after", no_tone, 1);
    base_acc = n_acc;
    tone(50, 20, 2);
    step(6);
    chk("t3_count",   n_acc - base_acc, 1);
    chk("t3_period",  last_p, 50);
    chk("t3_high",    last_h, 20);
    chk("t3_cleared", no_tone, 0);

    // minimum measurable tone
    rearm();
    base_acc = n_acc; base_ovr = n_ovr;
    tone(2, 1, 4);
    step(6);
    chk("min_count",   n_acc - base_acc, 3);
    chk("min_period",  last_p, 2);
    chk("min_high",    last_h, 1);
    chk("min_overrun", n_ovr - base_ovr, 0);

    // consumer stalled for three results
    rearm();
    period_ready = 1'b0;
    base_acc = n_acc; base_ovr = n_ovr;
    tone(7, 2, 4);
    step(6);
    chk("t2_valid",   period_valid, 1);
    chk("t2_period",  period_out, 7);
    chk("t2_high",    high_out, 2);
    chk("t2_overrun", n_ovr - base_ovr, 2);
    chk("t2_noacc",   n_acc - base_acc, 0);
    period_ready = 1'b1;
    step(2);
    chk("t2_accept",  n_acc - base_acc, 1);
    chk("t2_drop",    period_valid, 0);

    // enable dropped mid-measure discards the partial period
    rearm();
    audIn = 1'b1;
    step(5);
    audIn = 1'b0;
    step(3);
    enable = 1'b0;
    step(3);
    enable = 1'b1;
    step(2);
    base_acc = n_acc;
    tone(9, 4, 1);
    chk("t4_partial", n_acc - base_acc, 0);
    tone(9, 4, 2);
    step(6);
    chk("t4_count",  n_acc - base_acc, 2);
    chk("t4_period", last_p, 9);
    chk("t4_high",   last_h, 4);

    // asynchronous reset in the middle of a period
    period_ready = 1'b0;
    rearm();
    tone(20, 10, 2);
    chk("t5_pre_valid",  period_valid, 1);
    chk("t5_pre_period", period_out, 20);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t5_valid",   period_valid, 0);
    chk("t5_period",  period_out, 0);
    chk("t5_high",    high_out, 0);
    chk("t5_overrun", overrun, 0);
    chk("t5_no_tone", no_tone, 0);
    step(2);
    reset_n = 1'b1;
    period_ready = 1'b1;
    step(2);
    base_acc = n_acc;
    tone(13, 6, 2);
    step(6);
    chk("t5_count",  n_acc - base_acc, 1);
    chk("t5_period", last_p, 13);
    chk("t5_high",   last_h, 6);
`else
    // four raw periods averaged into one result
    base_acc = n_acc;
    tone(100, 50, 1);
    tone(102, 50, 1);
    tone(98, 50, 1);
    tone(104, 50, 1);
    step(6);
    chk("avg_none", n_acc - base_acc, 0);
    tone(10, 5, 1);
    step(6);
    chk("avg_count",  n_acc - base_acc, 1);
    chk("avg_period", last_p, 101);
    chk("avg_high",   last_h, 50);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
